seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector, the Mealy-style successor to the fixed 4-bit "1101" detector.
- Pattern length, reset pattern and overlap mode are set by parameters.
- The pattern can be reloaded at run time.
- A bit-enable qualifies each input bit, and a saturating match counter is provided.
- Sits on a 1-bit serial stream (deserialiser front-end / protocol framing) and flags the cycle in which the pattern completes.

---
 rtl/seq_detect_param.sv | 101 ++++++++++
 tb/tb_seq_detect_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a Mealy match pulse, run-time pattern reload,
// bit-enable qualification and a saturating match counter.
module seq_detect_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b0,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FW      = $clog2(N);
    localparam logic [FW-1:0]    FULL    = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } phase_t;

    logic [N-1:0]     pat_q, pat_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     window_s;
    logic             out_s;
    phase_t           phase_s;

    // Phase decode and Mealy match: only a fully filled window can complete the pattern
    always_comb begin
        phase_s  = FILL;
        window_s = {hist_q, in};
        out_s    = 1'b0;
        if (fcnt_q == FULL) begin
            phase_s = ARMED;
        end else begin
            phase_s = FILL;
        end
        if (!rst && !pat_load && en && (phase_s == ARMED) && (window_s == pat_q)) begin
            out_s = 1'b1;
        end else begin
            out_s = 1'b0;
        end
    end

    // Next-state logic; reset priority is applied in the register process
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fcnt_d = fcnt_q;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fcnt_d = '0;
        end else if (en) begin
            hist_d = window_s[N-2:0];
            // Non-overlapping mode demands N fresh bits after every match
            if (out_s && !OVERLAP) begin
                fcnt_d = '0;
            end else if (phase_s == ARMED) begin
                fcnt_d = FULL;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end else begin
            hist_d = hist_q;
        end
        if (out_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out       = out_s;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameterisations share one stimulus stream,
// each scenario task checks the relevant instance against hand-computed expectations.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic       pat_load;
    logic [3:0] pat4;
    logic [1:0] pat2;

    logic       out_def, out_ovl, out_sat, out_n2;
    logic [7:0] cnt_def, cnt_ovl, cnt_n2;
    logic [1:0] cnt_sat;

    int checks;
    int errors;

    seq_detect_param u_def (
        .clk(clk), .rst(rst), .en(en), .in(din), .pat_load(pat_load), .pat_in(pat4),
        .out(out_def), .match_cnt(cnt_def)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_ovl (
        .clk(clk), .rst(rst), .en(en), .in(din), .pat_load(pat_load), .pat_in(pat4),
        .out(out_ovl), .match_cnt(cnt_ovl)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .in(din), .pat_load(pat_load), .pat_in(pat4),
        .out(out_sat), .match_cnt(cnt_sat)
    );

    seq_detect_param #(.N(2), .PATTERN(2'b10), .OVERLAP(1'b0), .CNT_W(8)) u_n2 (
        .clk(clk), .rst(rst), .en(en), .in(din), .pat_load(pat_load), .pat_in(pat2),
        .out(out_n2), .match_cnt(cnt_n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after a rising edge, return at the falling edge for sampling
    task automatic drive(input logic e, input logic b);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pat_load = 1'b0;
        en       = e;
        din      = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        pat_load = 1'b0;
        en       = 1'b0;
        din      = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_def !== 8'd0 || cnt_ovl !== 8'd0 || cnt_sat !== 2'd0 || cnt_n2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d expected 0 0 0 0", cnt_def, cnt_ovl, cnt_sat, cnt_n2);
        end
        checks++;
        if ({out_def, out_ovl, out_sat, out_n2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out: got %b expected 0000", {out_def, out_ovl, out_sat, out_n2});
        end
    endtask

    task automatic test_basic_and_overlap();
        logic [6:0] seq;
        logic [6:0] exp_def;
        logic [6:0] exp_ovl;
        seq     = 7'b1101101;
        exp_def = 7'b0001000;
        exp_ovl = 7'b0001001;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[6-i]);
            checks++;
            if (out_def !== exp_def[6-i]) begin
                errors++;
                $display("FAIL basic_out bit%0d: got %b expected %b", i + 1, out_def, exp_def[6-i]);
            end
            checks++;
            if (out_ovl !== exp_ovl[6-i]) begin
                errors++;
                $display("FAIL overlap_out bit%0d: got %b expected %b", i + 1, out_ovl, exp_ovl[6-i]);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_def !== 8'd1) begin
            errors++;
            $display("FAIL basic_cnt: got %0d expected 1", cnt_def);
        end
        checks++;
        if (cnt_ovl !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt: got %0d expected 2", cnt_ovl);
        end
    endtask

    task automatic test_idle_hold();
        logic [4:0] seq;
        logic [4:0] ens;
        logic [4:0] exp;
        seq = 5'b11001;
        ens = 5'b11101;
        exp = 5'b00001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ens[4-i], seq[4-i]);
            checks++;
            if (out_def !== exp[4-i]) begin
                errors++;
                $display("FAIL idle_out step%0d: got %b expected %b", i + 1, out_def, exp[4-i]);
            end
        end
    endtask

    task automatic test_reset_midseq();
        logic [4:0] seq;
        logic [4:0] exp;
        do_reset();
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        // Armed with history 110; reset in the completing cycle must suppress the pulse
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;
        @(negedge clk);
        checks++;
        if (out_def !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate_out: got %b expected 0", out_def);
        end
        seq = 5'b11101;
        exp = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[4-i]);
            checks++;
            if (out_def !== exp[4-i]) begin
                errors++;
                $display("FAIL rst_mid_out step%0d: got %b expected %b", i + 1, out_def, exp[4-i]);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_def !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_cnt: got %0d expected 1", cnt_def);
        end
    endtask

    task automatic test_pat_load();
        logic [3:0] seq_a;
        logic [3:0] seq_b;
        logic [3:0] exp_a;
        seq_a = 4'b0110;
        seq_b = 4'b1101;
        exp_a = 4'b0001;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, seq_b[3-i]);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        // Load while armed with a completing bit present: must not pulse
        @(posedge clk);
        #1;
        pat_load = 1'b1;
        pat4     = 4'b0110;
        pat2     = 2'b10;
        en       = 1'b1;
        din      = 1'b1;
        @(negedge clk);
        checks++;
        if (out_def !== 1'b0) begin
            errors++;
            $display("FAIL load_gate_out: got %b expected 0", out_def);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq_a[3-i]);
            checks++;
            if (out_def !== exp_a[3-i]) begin
                errors++;
                $display("FAIL load_new_out bit%0d: got %b expected %b", i + 1, out_def, exp_a[3-i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq_b[3-i]);
            checks++;
            if (out_def !== 1'b0) begin
                errors++;
                $display("FAIL load_old_out bit%0d: got %b expected 0", i + 1, out_def);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_def !== 8'd2) begin
            errors++;
            $display("FAIL load_cnt: got %0d expected 2", cnt_def);
        end
    endtask

    task automatic test_saturate_and_n2();
        logic [7:0] exp_sat;
        logic [3:0] seq_n2;
        logic [3:0] exp_n2;
        exp_sat = 8'b00011111;
        seq_n2  = 4'b1010;
        exp_n2  = 4'b0101;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (out_sat !== exp_sat[7-i]) begin
                errors++;
                $display("FAIL sat_out bit%0d: got %b expected %b", i + 1, out_sat, exp_sat[7-i]);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_sat !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt: got %0d expected 3", cnt_sat);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq_n2[3-i]);
            checks++;
            if (out_n2 !== exp_n2[3-i]) begin
                errors++;
                $display("FAIL n2_out bit%0d: got %b expected %b", i + 1, out_n2, exp_n2[3-i]);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (cnt_n2 !== 8'd2) begin
            errors++;
            $display("FAIL n2_cnt: got %0d expected 2", cnt_n2);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        en       = 1'b0;
        din      = 1'b0;
        pat_load = 1'b0;
        pat4     = 4'b0000;
        pat2     = 2'b00;
        test_reset();
        test_basic_and_overlap();
        test_idle_hold();
        test_reset_midseq();
        test_pat_load();
        test_saturate_and_n2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
